// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: 2-flop synchroniser, mid-bit sampling FSM, LSB-first shift register.
// Emits a 1-cycle data_valid pulse per good frame and a 1-cycle frame_error pulse per bad stop bit.
module uart_receiver #(
    parameter int CLOCKS_PER_PULSE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLOCKS_PER_PULSE - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        rx_meta_r;
    logic        rx_s;
    logic [15:0] clk_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shreg_r;
    logic        cnt_clr_s;
    logic        bit_clr_s;
    logic        shift_en_s;
    logic        load_out_s;
    logic        valid_next_s;
    logic        ferr_next_s;

    // Synchroniser for the asynchronous serial line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Next-state and datapath control; the counter also restarts after every data-bit sample.
    always_comb begin
        state_next_s = state_r;
        cnt_clr_s    = 1'b0;
        bit_clr_s    = 1'b0;
        shift_en_s   = 1'b0;
        load_out_s   = 1'b0;
        valid_next_s = 1'b0;
        ferr_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_next_s = START;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (!rx_s) begin
                        state_next_s = DATA;
                        bit_clr_s    = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (clk_cnt_r == FULL_LAST) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (clk_cnt_r == FULL_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (rx_s) begin
                        load_out_s   = 1'b1;
                        valid_next_s = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        ferr_next_s  = 1'b1;
                        state_next_s = BREAK;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next_s = IDLE;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = BREAK;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            clk_cnt_r   <= 16'd0;
            bit_cnt_r   <= 3'd0;
            shreg_r     <= 8'd0;
            data_out    <= 8'd0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (cnt_clr_s) begin
                clk_cnt_r <= 16'd0;
            end else begin
                clk_cnt_r <= clk_cnt_r + 16'd1;
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shreg_r <= {rx_s, shreg_r[7:1]};
            end else begin
                shreg_r <= shreg_r;
            end
            if (load_out_s) begin
                data_out <= shreg_r;
            end else begin
                data_out <= data_out;
            end
            data_valid  <= valid_next_s;
            frame_error <= ferr_next_s;
            rx_busy     <= (state_next_s != IDLE);
        end
    end

endmodule
